// File: rtl/usb_fifo_rd_ctrl_pkg.sv
// rtl/usb_fifo_rd_ctrl_pkg.sv - shared defaults and pointer helpers for the USB FIFO
//
// Purpose : Default data/address widths for the dual-clock USB FIFO. Also provides
//           the pointer-width rule (address bits plus one wrap bit) shared by the
//           read controller, write controller and pointer synchronizer.
// Ports   : none (package)
package usb_fifo_rd_ctrl_pkg;

  localparam int unsigned USB_FIFO_WIDTH      = 8;
  localparam int unsigned USB_FIFO_ADDR_WIDTH = 6;
  localparam int unsigned USB_FIFO_DEPTH      = 1 << USB_FIFO_ADDR_WIDTH;

  // The extra MSB distinguishes a full FIFO from an empty one.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/usb_fifo_bin2gray.sv
// rtl/usb_fifo_bin2gray.sv - combinational binary to Gray converter
//
// Purpose : Converts a binary pointer to Gray code so that only one bit changes
//           per increment before it crosses clock domains. Used on both FIFO sides.
// Ports   : bin_i  [WIDTH-1:0]  binary input
//           gray_o [WIDTH-1:0]  Gray-coded output
module usb_fifo_bin2gray #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/usb_fifo_rd_ctrl.sv
// rtl/usb_fifo_rd_ctrl.sv - read-side controller for the dual-clock USB FIFO
//
// Purpose : Issues reads to the synchronous-read FIFO memory, hides its one-cycle
//           latency behind a first-word-fall-through valid/ready stream, and
//           exports a registered Gray read pointer for the write clock domain.
// Ports   : rdClk        read clock (only clock)
//           rst_n        asynchronous active-low reset
//           wrPtrBin     synchronized, binary-decoded write pointer
//           addrOut      memory read address
//           readEn       memory read issued this cycle
//           memData      memory read data, valid the cycle after readEn
//           flush        synchronous discard of all buffered data
//           dataOut      stream data
//           dataValid    stream data valid
//           dataReady    stream consumer ready
//           empty        nothing in flight or staged
//           numElements  unread words in memory + in flight + staged
//           rdPtrGray    registered Gray read pointer
module usb_fifo_rd_ctrl
  import usb_fifo_rd_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = USB_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = USB_FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = USB_FIFO_ADDR_WIDTH
) (
  input  logic                  rdClk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wrPtrBin,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  readEn,
  input  logic [FIFO_WIDTH-1:0] memData,
  input  logic                  flush,
  output logic [FIFO_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] numElements,
  output logic [ADDR_WIDTH:0]   rdPtrGray
);

  localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);

  if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("usb_fifo_rd_ctrl: FIFO_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      rd_gray_q, rd_gray_d;
  logic [PTR_W-1:0]      mem_avail;
  logic                  inflight_q, inflight_d;
  logic                  out_valid_q, out_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [FIFO_WIDTH-1:0] out_q, out_d;
  logic [FIFO_WIDTH-1:0] skid_q, skid_d;
  logic [1:0]            occ;
  logic                  pop;
  logic                  ret;
  logic                  issue;

  assign mem_avail = wrPtrBin - rd_ptr_q;

  // With the output register empty, the word returning from memory is shown
  // directly so a fresh word is visible the cycle after its read is issued.
  assign dataValid = out_valid_q | inflight_q;
  assign dataOut   = (!out_valid_q && inflight_q) ? memData : out_q;

  assign pop = dataValid & dataReady & ~flush;
  assign ret = inflight_q & ~flush;

  // In-flight reads count as occupied slots: out + skid can hold exactly two words.
  assign occ   = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
  assign issue = rst_n & (mem_avail != '0) & ~flush &
                 ((occ < 2'd2) | (pop & (occ == 2'd2)));

  assign readEn  = issue;
  assign addrOut = rd_ptr_q[ADDR_WIDTH-1:0];
  assign empty   = ~out_valid_q & ~inflight_q;

  assign numElements = rst_n ? ({1'b0, mem_avail} + {{PTR_W{1'b0}}, inflight_q} +
                                {{PTR_W{1'b0}}, out_valid_q} + {{PTR_W{1'b0}}, skid_valid_q})
                             : '0;

  usb_fifo_bin2gray #(
    .WIDTH(PTR_W)
  ) u_bin2gray (
    .bin_i (rd_ptr_q),
    .gray_o(rd_gray_d)
  );

  assign rdPtrGray = rd_gray_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    inflight_d   = issue;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (flush) begin
      rd_ptr_d     = wrPtrBin;
      inflight_d   = 1'b0;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (issue) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (out_valid_q) begin
        if (pop) begin
          if (skid_valid_q) begin
            out_d        = skid_q;
            skid_valid_d = ret;
            if (ret) skid_d = memData;
          end else begin
            out_valid_d = ret;
            if (ret) out_d = memData;
          end
        end else if (ret) begin
          skid_d       = memData;
          skid_valid_d = 1'b1;
        end
      end else if (ret && !pop) begin
        // Bypassed word was not taken: park it in the output register.
        out_d       = memData;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge rdClk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      rd_gray_q    <= '0;
      inflight_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      rd_gray_q    <= rd_gray_d;
      inflight_q   <= inflight_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_usb_fifo_rd_ctrl.sv
// tb/tb_usb_fifo_rd_ctrl.sv - directed self-checking bench for usb_fifo_rd_ctrl
module tb_usb_fifo_rd_ctrl;

  logic       rdClk;
  logic       rst_n;
  logic [6:0] wrPtrBin;
  logic [5:0] addrOut;
  logic       readEn;
  logic [7:0] memData;
  logic       flush;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       empty;
  logic [7:0] numElements;
  logic [6:0] rdPtrGray;

  logic [7:0] mem [0:63];
  int n_checks = 0;
  int n_errors = 0;

  usb_fifo_rd_ctrl #(
    .FIFO_WIDTH(8),
    .FIFO_DEPTH(64),
    .ADDR_WIDTH(6)
  ) dut (
    .rdClk      (rdClk),
    .rst_n      (rst_n),
    .wrPtrBin   (wrPtrBin),
    .addrOut    (addrOut),
    .readEn     (readEn),
    .memData    (memData),
    .flush      (flush),
    .dataOut    (dataOut),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .empty      (empty),
    .numElements(numElements),
    .rdPtrGray  (rdPtrGray)
  );

  initial rdClk = 1'b0;
  always #5 rdClk = ~rdClk;

  // Synchronous-read memory model
  initial memData = 8'h00;
  always @(posedge rdClk) begin
    if (readEn) memData <= mem[addrOut];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rdClk);
    #1;
  endtask

  initial begin
    int npop;
    int occ;
    logic pat [4];
    logic [5:0] exp_addr [4];
    logic [6:0] exp_gray [5];
    logic [7:0] exp_data [5];

    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
    exp_gray = '{7'd0, 7'd65, 7'd64, 7'd0, 7'd1};
    exp_data = '{8'h00, 8'd62, 8'd63, 8'h10, 8'h11};

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst_n = 1'b0; wrPtrBin = '0; flush = 1'b0; dataReady = 1'b0;
    cyc(); cyc();

    // Reset state
    check("rst_valid", dataValid, 0);
    check("rst_rden", readEn, 0);
    check("rst_empty", empty, 1);
    check("rst_num", numElements, 0);
    check("rst_gray", rdPtrGray, 0);
    check("rst_dout", dataOut, 0);
    rst_n = 1'b1;

    // FWFT latency
    mem[0] = 8'hA5; wrPtrBin = 7'd1;
    #1;
    check("fwft_rden", readEn, 1);
    check("fwft_addr", addrOut, 0);
    cyc();
    check("fwft_valid", dataValid, 1);
    check("fwft_data", dataOut, 8'hA5);
    check("fwft_nempty", empty, 0);
    dataReady = 1'b1;
    cyc();
    check("fwft_pop_valid", dataValid, 0);
    check("fwft_pop_empty", empty, 1);
    check("fwft_pop_num", numElements, 0);

    // Asynchronous reset mid-stream
    wrPtrBin = 7'd20;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("arst_valid", dataValid, 0);
    check("arst_rden", readEn, 0);
    check("arst_empty", empty, 1);
    check("arst_gray", rdPtrGray, 0);
    check("arst_num", numElements, 0);
    wrPtrBin = '0;
    cyc();
    rst_n = 1'b1;

    // Streaming 64 words
    for (int i = 0; i < 64; i++) mem[i] = i[7:0];
    wrPtrBin = 7'd64; dataReady = 1'b1;
    cyc(); #1;
    for (int i = 0; i < 64; i++) begin
      check("str_valid", dataValid, 1);
      check("str_data", dataOut, i);
      cyc(); #1;
    end
    check("str_empty", empty, 1);
    check("str_num", numElements, 0);
    check("str_gray64", rdPtrGray, 7'd96);

    // Backpressure, 10 words, ready pattern 1,0,0,1
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) mem[i] = 8'h10 + i[7:0];
    wrPtrBin = 7'd10;
    npop = 0;
    for (int c = 0; c < 60 && npop < 10; c++) begin
      dataReady = pat[c % 4];
      #1;
      check("bp_num", numElements, 10 - npop);
      occ = int'(dut.out_valid_q) + int'(dut.skid_valid_q) + int'(dut.inflight_q);
      check("bp_occ_le2", occ <= 2, 1);
      if (dataValid) begin
        check("bp_data", dataOut, 8'h10 + npop);
        if (dataReady) npop++;
      end
      cyc();
    end
    check("bp_count", npop, 10);
    #1;
    check("bp_empty", empty, 1);

    // Wrap: flush moves rdPtr to 126, then 4 words across the wrap
    flush = 1'b1; wrPtrBin = 7'd126; dataReady = 1'b0;
    #1;
    check("wr_flush_rden", readEn, 0);
    cyc();
    flush = 1'b0; wrPtrBin = 7'd2; dataReady = 1'b1;
    #1;
    check("wr_num", numElements, 4);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        check("wr_rden", readEn, 1);
        check("wr_addr", addrOut, exp_addr[k]);
      end else begin
        check("wr_rden_stop", readEn, 0);
      end
      if (k >= 1) begin
        check("wr_gray", rdPtrGray, exp_gray[k]);
        check("wr_valid", dataValid, 1);
        check("wr_data", dataOut, exp_data[k]);
      end
      if (k < 4) begin
        cyc(); #1;
      end
    end

    // Flush with a staged word and one in flight
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 8'h30 + i[7:0];
    wrPtrBin = 7'd5; dataReady = 1'b0;
    cyc(); #1;
    check("fl_rden1", readEn, 1);
    check("fl_valid1", dataValid, 1);
    check("fl_data1", dataOut, 8'h30);
    cyc(); #1;
    check("fl_num5", numElements, 5);
    check("fl_stall", readEn, 0);
    flush = 1'b1; wrPtrBin = 7'd7;
    #1;
    check("fl_rden_flush", readEn, 0);
    cyc();
    flush = 1'b0;
    #1;
    check("fl_valid0", dataValid, 0);
    check("fl_num0", numElements, 0);
    check("fl_empty", empty, 1);
    check("fl_rden0", readEn, 0);
    wrPtrBin = 7'd8;
    #1;
    check("fl_rden_new", readEn, 1);
    check("fl_addr_new", addrOut, 7);
    cyc(); #1;
    check("fl_valid_new", dataValid, 1);
    check("fl_data_new", dataOut, 8'h37);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
